arbiter_pipeline_n: RTL and testbench
=====================================

Name: arbiter_pipeline_n

Overview:
- Parametrised N-channel valid/ready arbiter with packet locking, selectable arbitration mode and a configurable-depth skid-buffered output pipeline.
- Merges REQ_WIDTH producer streams into one consumer stream.
- Tags every output beat with the index of the channel that produced it.
- Successor to the fixed 4-channel arbiter with a single skid stage; adds channel count, depth, packet lock and mode.

Parameters:
REQ_WIDTH, 4, number of requesting channels (2..32)
DW, 8, data width per channel
STAGES, 2, number of skid-buffer register slices on the output (1..4)
IDW, $clog2(REQ_WIDTH), width of the grant index tag

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-low; async assert, sync release assumed upstream
prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
valid_in  input  REQ_WIDTH  per-channel valid
last_in  input  REQ_WIDTH  per-channel end-of-packet marker, qualified by valid_in
data_in  input  REQ_WIDTH*DW  channel i data at bits [i*DW +: DW]
ready_out  output  REQ_WIDTH  per-channel ready; a transfer on channel i occurs when valid_in[i] & ready_out[i]
ready_in  input  1  downstream ready
valid_out  output  1  downstream valid
data_out  output  DW  granted data
last_out  output  1  end-of-packet marker, travels with data
id_out  output  IDW  index of the source channel, travels with data

Behaviour:
- Reset (rst=0): all skid stages empty, grant lock cleared, round-robin pointer = 0.
- While in reset: valid_out=0, data_out=0, last_out=0, id_out=0, ready_out=0.

Arbitration:
- Evaluated combinationally each cycle while unlocked.
- Round-robin: the highest-priority channel is ptr, then ptr+1 … wrapping mod REQ_WIDTH.
- Fixed: channel 0 has highest priority.
- A grant is one-hot and only issued to a channel with valid_in=1.
- With no valid channel there is no grant and ready_out=0.
- ready_out[i] = grant[i] & s0_ready, where s0_ready is the registered ready of the first skid stage. There is no combinational path from ready_in to ready_out.

Packet lock:
- Once a beat with last_in=0 is accepted from channel k, the grant stays on k until the beat with last_in=1 is accepted from k.
- While locked, other valid channels are ignored, and prio_mode changes are ignored until the lock releases.
- A single-beat packet (last_in=1 on the first beat) does not lock.
- Deasserting valid_in[k] mid-packet holds the lock. The arbiter stalls; there is no timeout.

Pointer update:
- Only on acceptance of a last_in=1 beat from channel k, in round-robin mode: ptr <= (k+1) mod REQ_WIDTH.
- Fixed mode leaves ptr unchanged.

Skid stages:
- Each stage holds a main register and a skid register.
- Upstream ready of each stage is registered and equals "skid register empty".
- A stage sustains 1 beat/cycle when downstream is always ready.
- Latency: a beat accepted at edge t appears on valid_out after edge t+STAGES-1. This is STAGES register hops; the first hop is the acceptance edge.
- Once valid_out=1, it holds, and data_out/last_out/id_out are stable, until ready_in=1.
- Ordering is strictly preserved. No beat is duplicated or dropped.
- Capacity is 2*STAGES beats in flight when ready_in is held low.

Simultaneous events:
- Acceptance of a last beat and a new arbitration decision in the same cycle: the next grant uses the updated ptr and lock state from the next cycle onward.
- A stage's skid is never written while full.

Reset mid-operation:
- All in-flight beats are discarded.
- Lock and pointer return to reset values.
- No partial-packet recovery.

Test Plan:
- Reset/idle: rst=0 with valid_in=4'b1111 → valid_out=0, ready_out=0. Release rst with ready_in=1 → first accepted beat is channel 0, id_out=0, valid_out=1 exactly STAGES cycles after release with STAGES=2.
- Round-robin fairness: all 4 channels stream single-beat packets (last_in=1111), ready_in=1 → id_out sequence 0,1,2,3,0,1,…, one beat per cycle with no bubbles.
- Packet lock: ch2 sends a 3-beat packet (last on beat 3) while ch0, ch1 and ch3 are valid → id_out=2,2,2 contiguous, then 3. Drop valid_in[2] for 2 cycles mid-packet → no other channel is granted.
- Fixed mode: prio_mode=1, ch1 and ch3 continuously valid with single beats → only id_out=1 appears. Switch to prio_mode=0 during a ch1 packet → the change takes effect only after ch1's last beat.
- Backpressure: ready_in=0 for 10 cycles under a full load → exactly 2*STAGES beats accepted, then ready_out=0, valid_out held with stable data. Release ready_in → all beats delivered in order with no loss.
- Mid-stream reset: assert rst with 3 beats in flight → valid_out falls immediately (asynchronously). After release, ptr=0 and there is no residual lock.

Source files
------------

// File: rtl/arbiter_pipeline_n_if.sv
`timescale 1ns/1ps
// Handshake bundle for arbiter_pipeline_n: REQ_WIDTH producer streams in, one id-tagged stream out.
// slave = arbiter side, master = producer/consumer side.
interface arbiter_pipeline_n_if #(
  parameter int REQ_WIDTH = 4,
  parameter int DW        = 8,
  parameter int IDW       = $clog2(REQ_WIDTH)
);
  logic                    prio_mode;
  logic [REQ_WIDTH-1:0]    valid_in;
  logic [REQ_WIDTH-1:0]    last_in;
  logic [REQ_WIDTH*DW-1:0] data_in;
  logic [REQ_WIDTH-1:0]    ready_out;
  logic                    ready_in;
  logic                    valid_out;
  logic [DW-1:0]           data_out;
  logic                    last_out;
  logic [IDW-1:0]          id_out;

  modport master (
    output prio_mode, valid_in, last_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, last_out, id_out
  );

  modport slave (
    input  prio_mode, valid_in, last_in, data_in, ready_in,
    output ready_out, valid_out, data_out, last_out, id_out
  );
endinterface

// File: rtl/arbiter_pipeline_n.sv
`timescale 1ns/1ps
// N-way packet-locking arbiter (round-robin or fixed) feeding STAGES skid slices; beat accepted at edge t is on valid_out after edge t+STAGES-1.
// Backpressure: each slice's upstream ready is its registered "skid empty" flag, so ready_out has no combinational path from ready_in.
module arbiter_pipeline_n #(
  parameter int REQ_WIDTH = 4,
  parameter int DW        = 8,
  parameter int STAGES    = 2,
  parameter int IDW       = $clog2(REQ_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  arbiter_pipeline_n_if.slave  bus
);
  localparam int PW = DW + IDW + 1;

  logic                 r_locked;
  logic                 r_lock_mode;
  logic [IDW-1:0]       r_lock_id;
  logic [IDW-1:0]       r_ptr;

  logic                 w_found;
  logic [IDW-1:0]       w_gid;
  int                   w_idx;
  logic [REQ_WIDTH-1:0] w_grant;
  logic [REQ_WIDTH-1:0] w_rdy_out;
  logic                 w_acc;
  logic                 w_last;
  logic                 w_eff_mode;
  logic [DW-1:0]        w_dat;
  logic [PW-1:0]        w_pay;

  logic [STAGES-1:0]          r_main_vld;
  logic [STAGES-1:0]          r_skid_vld;
  logic [STAGES-1:0][PW-1:0]  r_main;
  logic [STAGES-1:0][PW-1:0]  r_skid;
  logic [STAGES:0]            w_up_rdy;
  logic [STAGES:0]            w_dn_vld;
  logic [STAGES:0][PW-1:0]    w_dn_dat;

  // Grant selection: a held lock overrides both arbitration modes.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = 0;
    if (rst) begin
      if (r_locked) begin
        w_found = bus.valid_in[r_lock_id];
        w_gid   = r_lock_id;
      end else begin
        for (int j = 0; j < REQ_WIDTH; j++) begin
          w_idx = bus.prio_mode ? j : int'(r_ptr) + j;
          if (w_idx >= REQ_WIDTH) w_idx = w_idx - REQ_WIDTH;
          if (!w_found && bus.valid_in[w_idx]) begin
            w_found = 1'b1;
            w_gid   = IDW'(w_idx);
          end
        end
      end
    end
  end

  assign w_grant    = w_found ? (REQ_WIDTH'(1) << w_gid) : '0;
  assign w_rdy_out  = w_grant & {REQ_WIDTH{w_up_rdy[0]}};
  assign w_acc      = |(bus.valid_in & w_rdy_out);
  assign w_last     = bus.last_in[w_gid];
  assign w_dat      = bus.data_in[int'(w_gid)*DW +: DW];
  assign w_pay      = {w_last, w_gid, w_dat};
  assign w_eff_mode = r_locked ? r_lock_mode : bus.prio_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_locked    <= 1'b0;
      r_lock_mode <= 1'b0;
      r_lock_id   <= '0;
      r_ptr       <= '0;
    end else if (w_acc) begin
      if (w_last) begin
        r_locked <= 1'b0;
        if (!w_eff_mode)
          r_ptr <= (int'(w_gid) == REQ_WIDTH-1) ? '0 : w_gid + 1'b1;
      end else if (!r_locked) begin
        r_locked    <= 1'b1;
        r_lock_id   <= w_gid;
        r_lock_mode <= bus.prio_mode;
      end
    end
  end

  // Index s of w_up_rdy is the ready seen by slice s-1; the top entry is the consumer.
  assign w_up_rdy = {bus.ready_in, ~r_skid_vld};
  assign w_dn_vld = {r_main_vld, w_acc};
  assign w_dn_dat = {r_main, w_pay};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_vld <= '0;
      r_skid_vld <= '0;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_up_rdy[s+1] || !r_main_vld[s]) begin
          if (r_skid_vld[s]) begin
            r_main[s]     <= r_skid[s];
            r_main_vld[s] <= 1'b1;
            r_skid_vld[s] <= 1'b0;
          end else begin
            r_main_vld[s] <= w_dn_vld[s];
            if (w_dn_vld[s]) r_main[s] <= w_dn_dat[s];
          end
        end else if (w_dn_vld[s] && !r_skid_vld[s]) begin
          r_skid[s]     <= w_dn_dat[s];
          r_skid_vld[s] <= 1'b1;
        end
      end
    end
  end

  assign bus.ready_out = w_rdy_out;
  assign bus.valid_out = w_dn_vld[STAGES];
  assign {bus.last_out, bus.id_out, bus.data_out} = w_dn_dat[STAGES];

endmodule

// File: tb/tb_arbiter_pipeline_n.sv
`timescale 1ns/1ps
// Randomised and directed bench for arbiter_pipeline_n against a transaction-level arbitration model and an in-order scoreboard.
module tb_arbiter_pipeline_n;
  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int STAGES = 2;
  localparam int IDW    = 2;

  logic clk;
  logic rst;

  arbiter_pipeline_n_if #(.REQ_WIDTH(N), .DW(DW), .IDW(IDW)) bus ();

  arbiter_pipeline_n #(.REQ_WIDTH(N), .DW(DW), .STAGES(STAGES), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  logic [IDW+DW:0] sb[$];
  int out_ids[$];
  int exp_ids[$];

  // reference model state
  bit m_locked;
  bit m_lock_mode;
  int m_lock_id;
  int m_ptr;
  int pick;
  int acc_ch;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input logic pm);
    if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
    for (int j = 0; j < N; j++) begin
      int c;
      c = pm ? j : (m_ptr + j) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: output scoreboard, grant check, model update.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rst_valid_out", 64'(bus.valid_out), 64'(0));
      check_eq("rst_ready_out", 64'(bus.ready_out), 64'(0));
      check_eq("rst_data_out", 64'(bus.data_out), 64'(0));
      check_eq("rst_last_out", 64'(bus.last_out), 64'(0));
      check_eq("rst_id_out", 64'(bus.id_out), 64'(0));
      sb.delete();
      m_locked = 0; m_lock_mode = 0; m_lock_id = 0; m_ptr = 0;
    end else begin
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          check_eq("out_spurious", 64'(1), 64'(0));
        end else begin
          check_eq("out_beat", 64'({bus.id_out, bus.last_out, bus.data_out}), 64'(sb[0]));
          if (bus.ready_in) begin
            void'(sb.pop_front());
            out_ids.push_back(int'(bus.id_out));
          end
        end
      end
      pick = model_pick(bus.valid_in, bus.prio_mode);
      if (bus.ready_out != '0)
        check_eq("grant", 64'(bus.ready_out), (pick < 0) ? 64'(0) : (64'(1) << pick));
      acc_ch = -1;
      for (int c = 0; c < N; c++)
        if (bus.valid_in[c] && bus.ready_out[c] && acc_ch < 0) acc_ch = c;
      if (acc_ch >= 0) begin
        n_acc++;
        sb.push_back({IDW'(acc_ch), bus.last_in[acc_ch], bus.data_in[acc_ch*DW +: DW]});
        if (bus.last_in[acc_ch]) begin
          if (!(m_locked ? m_lock_mode : bus.prio_mode)) m_ptr = (acc_ch + 1) % N;
          m_locked = 0;
        end else if (!m_locked) begin
          m_locked = 1; m_lock_id = acc_ch; m_lock_mode = bus.prio_mode;
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic pm, input logic rdy);
    @(posedge clk);
    #1;
    bus.valid_in  = v;
    bus.last_in   = l;
    bus.prio_mode = pm;
    bus.ready_in  = rdy;
    for (int c = 0; c < N; c++) bus.data_in[c*DW +: DW] = DW'($urandom);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      step('0, '0, 1'b0, 1'b1);
      settle();
    end
    check_eq("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_ids(input string tag);
    check_eq({tag, "_count"}, 64'(out_ids.size()), 64'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < out_ids.size(); i++)
      check_eq({tag, "_id"}, 64'(out_ids[i]), 64'(exp_ids[i]));
  endtask

  logic [N-1:0] lk_v [8] = '{4'b0100, 4'b1111, 4'b1011, 4'b1011, 4'b1111, 4'b1011, 4'b1011, 4'b1011};
  logic [N-1:0] lk_l [8] = '{4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1011, 4'b1011, 4'b1011};
  logic pm;

  initial begin
    rst = 1'b0;
    bus.valid_in = '1; bus.last_in = '1; bus.prio_mode = 1'b0;
    bus.ready_in = 1'b1; bus.data_in = '0;
    repeat (3) settle();
    check_eq("idle_valid_out", 64'(bus.valid_out), 64'(0));
    check_eq("idle_ready_out", 64'(bus.ready_out), 64'(0));

    // release: first beat from ch0 appears STAGES edges later, then RR 0,1,2,3 with no bubbles
    step('1, '1, 1'b0, 1'b1);
    rst = 1'b1;
    for (int e = 1; e <= STAGES; e++) begin
      @(posedge clk);
      settle();
      check_eq("lat_valid", 64'(bus.valid_out), 64'(e == STAGES));
    end
    check_eq("lat_id", 64'(bus.id_out), 64'(0));
    for (int i = 1; i < 12; i++) begin
      step('1, '1, 1'b0, 1'b1);
      settle();
      check_eq("rr_valid", 64'(bus.valid_out), 64'(1));
      check_eq("rr_id", 64'(bus.id_out), 64'(i % N));
    end
    drain();

    // packet lock on ch2 with a two-cycle valid gap
    out_ids.delete();
    for (int c = 0; c < 8; c++) begin
      step(lk_v[c], lk_l[c], 1'b0, 1'b1);
      settle();
      if (c == 2 || c == 3) check_eq("lock_stall_ready", 64'(bus.ready_out), 64'(0));
    end
    drain();
    exp_ids = '{2, 2, 2, 3, 0, 1};
    check_ids("lock");

    // fixed priority, then a mode switch inside a ch1 packet
    out_ids.delete();
    repeat (8) step(4'b1010, 4'b1111, 1'b1, 1'b1);
    step(4'b1010, 4'b0000, 1'b1, 1'b1);
    step(4'b1010, 4'b0000, 1'b0, 1'b1);
    repeat (4) step(4'b1010, 4'b1010, 1'b0, 1'b1);
    drain();
    exp_ids = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3, 1, 3};
    check_ids("fixed");

    // backpressure: capacity is 2*STAGES, then delivered in order
    out_ids.delete();
    n_acc = 0;
    repeat (10) step('1, '1, 1'b0, 1'b0);
    settle();
    check_eq("bp_accepted", 64'(n_acc), 64'(2*STAGES));
    check_eq("bp_ready_out", 64'(bus.ready_out), 64'(0));
    check_eq("bp_valid_out", 64'(bus.valid_out), 64'(1));
    drain();
    exp_ids = '{0, 1, 2, 3};
    check_ids("bp");

    // random traffic
    pm = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) pm = ~pm;
      step(N'($urandom), N'($urandom), pm, ($urandom_range(0, 3) != 0));
    end
    repeat (8) step('1, '1, 1'b0, 1'b1);
    drain();

    // mid-stream reset with a ch3 packet open and 3 beats in flight
    repeat (3) step(4'b1000, 4'b0000, 1'b0, 1'b0);
    settle();
    check_eq("pre_rst_valid", 64'(bus.valid_out), 64'(1));
    step('0, '0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("async_valid_out", 64'(bus.valid_out), 64'(0));
    check_eq("async_ready_out", 64'(bus.ready_out), 64'(0));
    repeat (2) step('0, '0, 1'b0, 1'b0);
    out_ids.delete();
    step('1, '1, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (3) step('1, '1, 1'b0, 1'b1);
    drain();
    exp_ids = '{0, 1, 2, 3};
    check_ids("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
